mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-beat memory port between the instruction cache (read-only)
//  and the data cache (read/write). Sits between the i_cache/d_cache miss
//  interfaces and the memory/AXI bridge. Grants one requester at a time and
//  latches that requester's address, write flag and write data. Holds the memory
//  strobe until the memory answers, then routes ready and read data back.
// PARAMETERS
//  A_WIDTH  32  address width, both requesters and memory side
//  D_WIDTH  32  data width
// PORTS
//  clk        in   1        single clock, all state on posedge
//  clrn       in   1        synchronous active-low reset
//  i_strobe   in   1        icache miss request (read)
//  i_a        in   A_WIDTH  icache request address
//  i_dout     out  D_WIDTH  read data to icache
//  i_ready    out  1        icache transfer done, 1-cycle pulse
//  d_strobe   in   1        dcache request
//  d_rw       in   1        1 = write, 0 = read
//  d_a        in   A_WIDTH  dcache request address
//  d_din      in   D_WIDTH  dcache write data
//  d_dout     out  D_WIDTH  read data to dcache
//  d_ready    out  1        dcache transfer done, 1-cycle pulse
//  mem_a      out  A_WIDTH  memory address (registered)
//  mem_wdata  out  D_WIDTH  memory write data (registered)
//  mem_rw     out  1        memory write flag (registered)
//  mem_strobe out  1        memory request
//  mem_rdata  in   D_WIDTH  memory read data
//  mem_ready  in   1        memory done, 1-cycle pulse
// BEHAVIOUR
//  - FSM states: IDLE, GNT_I, GNT_D.
//  - Reset values: state = IDLE; mem_strobe, mem_rw, i_ready, d_ready = 0;
//    mem_a, mem_wdata = 0; last_gnt = I.
//  - Transitions:
//    - IDLE: any strobe high at edge N -> GNT_x at N+1. mem_a, mem_rw and
//      mem_wdata are latched from the winner at the same edge.
//      icache latch sets mem_rw = 0 and mem_wdata = 0.
//    - GNT_x: mem_strobe = 1 combinationally from the state.
//      mem_ready = 1 -> x_ready = 1 in the same cycle, and state = IDLE at the
//      next edge.
//  - Minimum latency: request -> ready is 2 cycles when memory answers
//    immediately. Back-to-back grants are separated by at least 1 IDLE cycle.
//  - Read data: x_dout = mem_rdata combinationally at all times. It is valid
//    only while x_ready = 1.
//  - Ready gating: x_ready = mem_ready & (state == GNT_x) & x_strobe.
//    The non-granted ready is 0.
//  - Abandon: a granted requester may drop its strobe, e.g. on a pipeline
//    flush. The memory transaction still completes, because mem_strobe stays
//    high until mem_ready. The response is then discarded: no ready pulse.
//    The FSM returns to IDLE on mem_ready.
//  - Latched fields: mem_a, mem_rw and mem_wdata must not change during
//    GNT_x, even if the requester changes its inputs.
//  - mem_ready while IDLE is ignored: no ready pulse, no state change.
//  - Simultaneous requests in IDLE: the winner is set by the arbitration
//    policy in CONFIGURATION.
//  - Reset mid-transaction: state = IDLE and mem_strobe = 0 at the next edge.
//    The outstanding memory transfer is abandoned. The memory side must accept
//    that on clrn.
// CONFIGURATION
//  - ARB_RR_EN defined: round-robin. On simultaneous requests the requester NOT
//    equal to last_gnt wins. last_gnt updates on every grant. Reset last_gnt = I,
//    so the dcache wins the first tie.
//  - ARB_RR_EN undefined: fixed priority, dcache over icache. The last_gnt
//    register is not instantiated.
// STRUCTURE
//  - Package cache_arb_pkg holds:
//    - arb_state_t enum {IDLE, GNT_I, GNT_D};
//    - req_id_t enum {REQ_I, REQ_D};
//    - localparam ARB_RESET_LAST = REQ_I.
//  - One sub-module: arb_pick. Combinational winner selection from
//    (i_strobe, d_strobe, last_gnt). It holds the ARB_RR_EN ifdef so the FSM
//    body stays policy-free.
// TESTING
//  1. i_strobe=1, i_a=0x0000_1000; mem_ready 1 cycle after mem_strobe, with
//     mem_rdata=0xDEAD_BEEF -> mem_a=0x1000, mem_rw=0,
//     i_ready pulse with i_dout=0xDEAD_BEEF, d_ready=0.
//  2. d_strobe=1, d_rw=1, d_a=0x20, d_din=0x1234_5678 -> mem_rw=1,
//     mem_wdata=0x1234_5678, d_ready pulse after mem_ready.
//     Change d_din mid-grant -> mem_wdata unchanged.
//  3. i_strobe and d_strobe rise together, held for 3 transfers ->
//     fixed priority: D,D,D.
//     ARB_RR_EN: D,I,D (first grant goes to D).
//  4. Grant I, drop i_strobe before mem_ready -> mem_strobe stays 1 until
//     mem_ready, no i_ready pulse, state returns to IDLE.
//  5. mem_ready pulsed while IDLE -> no ready pulse, no state change.
//     clrn=0 during GNT_D -> mem_strobe=0 and state IDLE next cycle.
//  6. mem_ready delayed 10 cycles -> mem_strobe and latched mem_a stable for
//     all 10 cycles, exactly one ready pulse.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared state/requester types for the cache memory-port arbiter
package cache_arb_pkg;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;

  localparam req_id_t ARB_RESET_LAST = REQ_I;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection for the cache arbiter
// ARB_RR_EN: round-robin on ties against last_gnt; otherwise dcache has fixed priority.
module arb_pick
  import cache_arb_pkg::*;
(
  input  logic    i_strobe,
  input  logic    d_strobe,
  input  req_id_t last_gnt,
  output logic    any_req,
  output req_id_t winner
);

  assign any_req = i_strobe | d_strobe;

`ifdef ARB_RR_EN
  always_comb begin
    winner = REQ_I;
    if (i_strobe && d_strobe) begin
      // On a tie the side that did not win last time goes first.
      winner = (last_gnt == REQ_I) ? REQ_D : REQ_I;
    end else if (d_strobe) begin
      winner = REQ_D;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign winner = d_strobe ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one single-beat memory port between icache and dcache
// ARB_RR_EN selects round-robin tie-breaking (adds the last_gnt register).
module mem_bus_arbiter
  import cache_arb_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               i_strobe,
  input  logic [A_WIDTH-1:0] i_a,
  output logic [D_WIDTH-1:0] i_dout,
  output logic               i_ready,
  input  logic               d_strobe,
  input  logic               d_rw,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [D_WIDTH-1:0] d_din,
  output logic [D_WIDTH-1:0] d_dout,
  output logic               d_ready,
  output logic [A_WIDTH-1:0] mem_a,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic               mem_rw,
  output logic               mem_strobe,
  input  logic [D_WIDTH-1:0] mem_rdata,
  input  logic               mem_ready
);

  arb_state_t state;
  req_id_t    last_gnt;
  req_id_t    winner;
  logic       any_req;

  arb_pick u_pick (
    .i_strobe (i_strobe),
    .d_strobe (d_strobe),
    .last_gnt (last_gnt),
    .any_req  (any_req),
    .winner   (winner)
  );

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!clrn) begin
      last_gnt <= ARB_RESET_LAST;
    end else if (state == IDLE && any_req) begin
      last_gnt <= winner;
    end
  end
`else
  assign last_gnt = ARB_RESET_LAST;
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= IDLE;
      mem_a     <= '0;
      mem_wdata <= '0;
      mem_rw    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (winner == REQ_D) begin
              state     <= GNT_D;
              mem_a     <= d_a;
              mem_rw    <= d_rw;
              mem_wdata <= d_din;
            end else begin
              state     <= GNT_I;
              mem_a     <= i_a;
              mem_rw    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end
        // The transfer always runs to mem_ready, even if the requester has gone away.
        GNT_I, GNT_D: begin
          if (mem_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_strobe = (state == GNT_I) || (state == GNT_D);
  assign i_ready    = mem_ready & (state == GNT_I) & i_strobe;
  assign d_ready    = mem_ready & (state == GNT_D) & d_strobe;
  assign i_dout     = mem_rdata;
  assign d_dout     = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and random checks of mem_bus_arbiter against a transaction model
// Expected tie order follows ARB_RR_EN when defined.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        i_strobe, d_strobe, d_rw, mem_ready;
  logic [31:0] i_a, d_a, d_din, mem_rdata;
  logic [31:0] i_dout, d_dout, mem_a, mem_wdata;
  logic        i_ready, d_ready, mem_rw, mem_strobe;

  int total = 0;
  int bad   = 0;

  // Memory as seen by the DUT's port, and memory as the requesters intended it.
  logic [31:0] dut_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          ref_last_d;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.A_WIDTH(32), .D_WIDTH(32)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .i_strobe   (i_strobe),
    .i_a        (i_a),
    .i_dout     (i_dout),
    .i_ready    (i_ready),
    .d_strobe   (d_strobe),
    .d_rw       (d_rw),
    .d_a        (d_a),
    .d_din      (d_din),
    .d_dout     (d_dout),
    .d_ready    (d_ready),
    .mem_a      (mem_a),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_strobe (mem_strobe),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dut_read(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  // 1 = dcache wins.
  function automatic bit ref_pick(input bit ri, input bit rd);
`ifdef ARB_RR_EN
    if (ri && rd) return !ref_last_d;
`endif
    return rd;
  endfunction

  task automatic do_reset();
    clrn = 1'b0; i_strobe = 1'b0; d_strobe = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    clrn = 1'b1;
    ref_last_d = 1'b0;
  endtask

  // One memory transaction, with the bench acting as the memory behind the port.
  task automatic do_txn(input bit ri, input bit rd, input logic [31:0] ai, input logic [31:0] ad,
                        input bit rw, input logic [31:0] din, input int delay, input bit drop,
                        input bit scramble, output bit got_d);
    bit          w;
    logic [31:0] ea, ewd;
    bit          erw;
    i_strobe = ri; d_strobe = rd; i_a = ai; d_a = ad; d_rw = rw; d_din = din;
    w   = ref_pick(ri, rd);
    ea  = w ? ad : ai;
    erw = w ? rw : 1'b0;
    ewd = w ? din : 32'h0;
    tick(); #2;
    chk("grant_strobe", mem_strobe, 1);
    chk("grant_a", mem_a, ea);
    chk("grant_rw", mem_rw, erw);
    chk("grant_wdata", mem_wdata, ewd);
    if (scramble) begin
      i_a = ~ai; d_a = ~ad; d_din = ~din; d_rw = ~rw;
    end
    if (drop) begin
      if (w) d_strobe = 1'b0; else i_strobe = 1'b0;
    end
    for (int k = 0; k < delay; k++) begin
      chk("wait_i_ready", i_ready, 0);
      chk("wait_d_ready", d_ready, 0);
      tick(); #2;
      chk("wait_strobe", mem_strobe, 1);
      chk("wait_a", mem_a, ea);
      chk("wait_wdata", mem_wdata, ewd);
    end
    if (mem_rw) dut_mem[mem_a] = mem_wdata;
    mem_rdata = mem_rw ? $urandom : dut_read(mem_a);
    mem_ready = 1'b1;
    #1;
    chk("resp_i_ready", i_ready, (!w && !drop));
    chk("resp_d_ready", d_ready, (w && !drop));
    got_d = d_ready;
    if (!erw) chk("resp_dout", w ? d_dout : i_dout, ref_read(ea));
    if (erw) ref_mem[ea] = din;
    ref_last_d = w;
    tick();
    mem_ready = 1'b0;
    #2;
    chk("back_idle_strobe", mem_strobe, 0);
  endtask

  task automatic idle();
    i_strobe = 1'b0; d_strobe = 1'b0;
    tick();
  endtask

  initial begin
    bit       g;
    bit [2:0] seq;
    bit       ri, rd;
    mem_rdata = 32'h0; i_a = 32'h0; d_a = 32'h0; d_din = 32'h0; d_rw = 1'b0;
    do_reset();
    #2;
    chk("rst_strobe", mem_strobe, 0);
    chk("rst_a", mem_a, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rw", mem_rw, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);

    // icache read, memory answers one cycle after strobe.
    dut_mem[32'h1000] = 32'hDEAD_BEEF;
    ref_mem[32'h1000] = 32'hDEAD_BEEF;
    do_txn(1, 0, 32'h1000, 32'h0, 0, 32'h0, 1, 0, 0, g);
    idle();

    // dcache write, inputs changed during the grant.
    do_txn(0, 1, 32'h0, 32'h20, 1, 32'h1234_5678, 1, 0, 1, g);
    chk("t2_mem_stored", dut_read(32'h20), 32'h1234_5678);
    idle();

    // Simultaneous requests held for three transfers.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      do_txn(1, 1, 32'h40 + n * 4, 32'h80 + n * 4, 0, 32'h0, 0, 0, 0, g);
      seq[2 - n] = g;
    end
`ifdef ARB_RR_EN
    chk("tie_sequence", seq, 3'b101);
`else
    chk("tie_sequence", seq, 3'b111);
`endif
    idle();

    // icache abandons its request mid-grant.
    do_txn(1, 0, 32'h300, 32'h0, 0, 32'h0, 2, 1, 0, g);
    idle();

    // mem_ready while IDLE must be ignored.
    mem_ready = 1'b1;
    #1;
    chk("idle_rdy_i", i_ready, 0);
    chk("idle_rdy_d", d_ready, 0);
    tick();
    mem_ready = 1'b0;
    #2;
    chk("idle_rdy_state", mem_strobe, 0);

    // Reset during a dcache grant.
    d_strobe = 1'b1; d_rw = 1'b1; d_a = 32'h500; d_din = 32'h55;
    tick(); #2;
    chk("pre_rst_strobe", mem_strobe, 1);
    clrn = 1'b0;
    tick(); #2;
    chk("mid_rst_strobe", mem_strobe, 0);
    chk("mid_rst_a", mem_a, 0);
    clrn = 1'b1; d_strobe = 1'b0; mem_ready = 1'b1;
    #1;
    chk("mid_rst_no_ready", d_ready, 0);
    tick();
    mem_ready = 1'b0;
    ref_last_d = 1'b0;

    // Slow memory: ten wait cycles.
    do_txn(0, 1, 32'h0, 32'h600, 0, 32'h9, 10, 0, 1, g);
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) rd = 1'b1;
      do_txn(ri, rd, 32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 15)) << 2,
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), g);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
